// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 mux through channels 0..3 and presents the sampled word over valid/ready.
// Define MUX_SCAN_CONTINUOUS_EN to restart a scan at every handshake regardless of start.
module mux_scan_sampler #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       muxout,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [1:0] nidx;
  logic [3:0] cnt;
  logic [3:0] assembly;
  logic       restart;

  assign nidx = idx + 2'd1;

`ifdef MUX_SCAN_CONTINUOUS_EN
  assign restart = 1'b1;
`else
  assign restart = start;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 4'd0;
      address0   <= 1'b0;
      address1   <= 1'b0;
      busy       <= 1'b0;
      word       <= 4'b0000;
      word_valid <= 1'b0;
      assembly   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETTLE;
            idx      <= 2'd0;
            cnt      <= 4'd0;
            address0 <= 1'b0;
            address1 <= 1'b0;
            busy     <= 1'b1;
            assembly <= 4'b0000;
          end
        end
        SETTLE: begin
          if (cnt == LAST) begin
            cnt           <= 4'd0;
            assembly[idx] <= muxout;
            if (idx != 2'd3) begin
              idx      <= nidx;
              address0 <= nidx[0];
              address1 <= nidx[1];
            end else begin
              // final sample goes straight into word alongside the first three
              word       <= {muxout, assembly[2:0]};
              word_valid <= 1'b1;
              idx        <= 2'd0;
              address0   <= 1'b0;
              address1   <= 1'b0;
              state      <= PRESENT;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PRESENT: begin
          if (word_valid && word_ready) begin
            word_valid <= 1'b0;
            if (restart) begin
              state    <= SETTLE;
              idx      <= 2'd0;
              cnt      <= 4'd0;
              assembly <= 4'b0000;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_scan_sampler.md
# mux_scan_sampler

Sequencer that sits directly upstream and downstream of the 4:1 structural multiplexer. It drives the mux select lines `address0`/`address1` through channels 0..3, waits a programmable settle time on each channel for the gate-level mux path to resolve, and samples the mux output. It assembles the four samples into a 4-bit word and presents that word to a consumer over a valid/ready handshake.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles each channel is held before its sample is taken. Legal range 1..15; the counter is 4 bits.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin a scan; sampled only in IDLE, or at the handshake edge in PRESENT.
- `muxout`  input  1  output of the 4:1 mux.
- `address0`  output  1  mux select LSB; equals channel index bit 0.
- `address1`  output  1  mux select MSB; equals channel index bit 1.
- `busy`  output  1  high in any state other than IDLE.
- `word`  output  4  last completed scan; bit i is the sample of mux input i.
- `word_valid`  output  1  `word` holds an unconsumed result.
- `word_ready`  input  1  consumer accepts `word` when both `word_valid` and `word_ready` are high at a rising edge.

## Operation
- States: IDLE, SETTLE, PRESENT. All outputs are registered.
- Reset (asynchronous) forces the following; any partial scan is discarded:
  - state = IDLE
  - channel index = 0
  - settle count = 0
  - `address0` = `address1` = 0
  - `busy` = 0
  - `word` = 4'b0000
  - `word_valid` = 0
  - assembly register = 0
- IDLE -> SETTLE when `start` = 1. Index = 0, count = 0, address = 00.
- SETTLE:
  - count increments each cycle.
  - At the edge where count = SETTLE_CYCLES-1, `muxout` is written into assembly bit [index] and count returns to 0.
  - If index < 3: index increments and the address lines update at that same edge.
  - If index = 3: the complete assembly (including the bit just sampled) loads into `word`, `word_valid` goes to 1, address returns to 00, state -> PRESENT.
- PRESENT:
  - `word` and `word_valid` are held until the handshake.
  - At the handshake edge `word_valid` goes to 0. The next state is SETTLE (new scan, index 0) if `start` = 1, otherwise IDLE.
- `start` in SETTLE is ignored. Requests are neither queued nor counted.
- `word` keeps its previous value through a new scan and changes only at the final-sample edge.
- Channel mapping: address1:address0 = 00 selects in0, 01 selects in1, 10 selects in2, 11 selects in3.

## Timing
- Each channel is held for exactly SETTLE_CYCLES cycles, and its sample is taken at the edge that ends the hold.
- Latency: `word_valid` rises 4*SETTLE_CYCLES cycles after the edge that accepted `start`.
- Minimum period between words is 4*SETTLE_CYCLES+1 cycles. This requires `word_ready` high and a restart at every handshake.
- If `word_ready` is already high when `word_valid` rises, the handshake completes on the next edge; `word_valid` is high for exactly 1 cycle.
- `muxout` must be stable for the final cycle of each hold. The block does not synchronize `muxout`.

## Configuration
- `MUX_SCAN_CONTINUOUS_EN` defined: at the handshake edge the block always restarts a scan (PRESENT -> SETTLE) regardless of `start`. After the first `start`, it returns to IDLE only on reset.
- Not defined: a restart requires `start` = 1 at the handshake edge; otherwise PRESENT -> IDLE.

## Test plan
- Reset values: assert `reset` mid-cycle with no clock edge -> all outputs read zero immediately.
- Single scan, SETTLE_CYCLES=2:
  - Stimulus: inputs in3..in0 = 1,0,1,0, one-cycle `start` pulse, `word_ready` = 1.
  - Required: address sequence 00,01,10,11, each held 2 cycles; `word` = 4'b1010 with `word_valid` high 8 cycles after start, for 1 cycle.
- Backpressure:
  - Stimulus: hold `word_ready` low 5 cycles after `word_valid` rises, while changing the mux inputs.
  - Required: `word` stays 4'b1010; `busy` stays 1; address stays 00; handshake completes on the first edge with `word_ready` = 1.
- Start during scan:
  - Stimulus: pulse `start` in SETTLE.
  - Required: no effect; exactly one word is produced, then IDLE.
- Reset mid-scan:
  - Stimulus: assert `reset` while index = 2.
  - Required: outputs return to reset values; a following scan with inputs = 4'b0111 yields `word` = 4'b0111 with no stale bits.
- Back-to-back, SETTLE_CYCLES=1, `start` and `word_ready` held high:
  - Required: `word_valid` pulses every 5 cycles.
  - With `MUX_SCAN_CONTINUOUS_EN` defined, the same cadence is required with `start` low after the first pulse.
